// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-stage divider.
// Op and state encodings plus the two's-complement helper used for sign fix-up.
package alu_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  localparam logic [XLEN-1:0] DIV_ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] DIV_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_OUT  = 2'b11
  } div_state_e;

  function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] x);
    return ~x + 1'b1;
  endfunction

endpackage

// File: rtl/alu_div_step.sv
// One radix-2 restoring division iteration on magnitudes; purely combinational.
// Kept separate so two instances can later be chained for 2 bits per cycle.
module alu_div_step #(
  parameter int XLEN = alu_pkg::XLEN
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_nxt,
  output logic [XLEN-1:0] q_nxt
);

  logic [XLEN+1:0] shifted;
  logic [XLEN:0]   trial;
  logic            ge;

  always_comb begin
    shifted = {rem, q[XLEN-1]};
    ge      = shifted >= {2'b00, divisor};
    trial   = shifted[XLEN:0] - {1'b0, divisor};
    rem_nxt = ge ? trial : shifted[XLEN:0];
    q_nxt   = {q[XLEN-2:0], ge};
  end

endmodule

// File: rtl/alu_div.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU: 34-cycle start-to-done, 1 cycle on div-by-zero/overflow.
// No input backpressure: start is ignored unless idle; kill aborts without a done pulse.
module alu_div import alu_pkg::*; #(
  parameter int XLEN  = alu_pkg::XLEN,
  parameter int CNT_W = alu_pkg::CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] data0,
  input  logic [XLEN-1:0] data1,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] ALU_result
);

  div_state_e      state, state_nxt;
  logic [XLEN-1:0] q, divisor, result;
  logic [XLEN:0]   rem;
  logic [CNT_W-1:0] cnt;
  div_op_e         op_q;
  logic            neg0, neg1, done_q;

  logic [XLEN:0]   rem_step;
  logic [XLEN-1:0] q_step;

  logic            is_signed, n0, n1, div_zero, ovf;
  logic [XLEN-1:0] abs0, abs1, fast_res, q_fix, r_fix;
  logic            accept, fast, step_en, fix_en;

  alu_div_step #(.XLEN(XLEN)) u_step (
    .rem     (rem),
    .q       (q),
    .divisor (divisor),
    .rem_nxt (rem_step),
    .q_nxt   (q_step)
  );

  always_comb begin
    is_signed = ~op[0];
    n0        = is_signed & data0[XLEN-1];
    n1        = is_signed & data1[XLEN-1];
    abs0      = n0 ? twos_neg(data0) : data0;
    abs1      = n1 ? twos_neg(data1) : data1;
    div_zero  = (data1 == '0);
    ovf       = is_signed && (data0 == DIV_INT_MIN) && (data1 == DIV_ALL_ONES);
    if (div_zero)
      fast_res = op[1] ? data0 : DIV_ALL_ONES;
    else
      fast_res = op[1] ? '0 : DIV_INT_MIN;
    // Remainder takes the dividend's sign; quotient is negative when signs differ.
    q_fix     = (neg0 ^ neg1) ? twos_neg(q) : q;
    r_fix     = neg0 ? twos_neg(rem[XLEN-1:0]) : rem[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    fast      = 1'b0;
    step_en   = 1'b0;
    fix_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !kill) begin
          accept = 1'b1;
          if (div_zero || ovf) begin
            fast      = 1'b1;
            state_nxt = S_OUT;
          end else begin
            state_nxt = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (kill) begin
          state_nxt = S_IDLE;
        end else begin
          step_en = 1'b1;
          if (cnt == CNT_W'(XLEN-1)) state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        state_nxt = S_IDLE;
        if (!kill) fix_en = 1'b1;
      end
      S_OUT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      divisor <= '0;
      rem     <= '0;
      cnt     <= '0;
      op_q    <= DIV_OP_DIV;
      neg0    <= 1'b0;
      neg1    <= 1'b0;
      result  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= fast | fix_en;
      if (accept) begin
        q       <= abs0;
        divisor <= abs1;
        rem     <= '0;
        cnt     <= '0;
        op_q    <= div_op_e'(op);
        neg0    <= n0;
        neg1    <= n1;
        if (fast) result <= fast_res;
      end
      if (step_en) begin
        rem <= rem_step;
        q   <= q_step;
        cnt <= cnt + 1'b1;
      end
      if (fix_en)
        result <= ((op_q == DIV_OP_REM) || (op_q == DIV_OP_REMU)) ? r_fix : q_fix;
    end
  end

  assign busy       = (state == S_CALC) || (state == S_FIX);
  assign done       = done_q;
  assign ALU_result = result;

endmodule

// File: tb/tb_alu_div.sv
// Randomized self-checking bench for alu_div against an arithmetic reference model.
module tb_alu_div;

  logic        clk = 1'b0;
  logic        rst, start, kill, busy, done;
  logic [1:0]  op;
  logic [31:0] data0, data1, ALU_result;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_exp;

  alu_div dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .data0      (data0),
    .data1      (data1),
    .kill       (kill),
    .busy       (busy),
    .done       (done),
    .ALU_result (ALU_result)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    bit is_rem, sgn;
    sa = a;
    sb = b;
    is_rem = o[1];
    sgn = !o[0];
    if (b == 0) return is_rem ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'h0 : 32'h8000_0000;
      return is_rem ? 32'(sa % sb) : 32'(sa / sb);
    end
    return is_rem ? (a % b) : (a / b);
  endfunction

  function automatic bit is_fast(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int lat, bc;
    bit fst;
    exp = ref_div(o, a, b);
    fst = is_fast(o, a, b);
    op = o; data0 = a; data1 = b; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    bc = busy ? 1 : 0;
    while (!done && lat < 60) begin
      tick();
      lat++;
      if (busy) bc++;
    end
    chk({tag, " result"}, ALU_result, exp);
    chk({tag, " latency"}, 32'(lat), fst ? 32'd1 : 32'd34);
    chk({tag, " busy_cycles"}, 32'(bc), fst ? 32'd0 : 32'd33);
    tick();
    chk({tag, " done_pulse"}, {31'b0, done}, 32'd0);
    chk({tag, " hold"}, ALU_result, exp);
    last_exp = exp;
  endtask

  initial begin
    int dones, lat;
    logic [1:0]  o;
    logic [31:0] a, b;
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = 2'b00; data0 = '0; data1 = '0;
    last_exp = '0;
    tick(); tick();
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset result", ALU_result, 32'd0);
    rst = 1'b0;
    tick();

    run_op("divu 100/7", 2'b01, 32'd100, 32'd7);
    run_op("remu 100/7", 2'b11, 32'd100, 32'd7);
    run_op("div -7/2",   2'b00, 32'hFFFF_FFF9, 32'd2);
    run_op("rem -7/2",   2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op("rem 7/-2",   2'b10, 32'd7, 32'hFFFF_FFFE);
    run_op("divu x/0",   2'b01, 32'h1234, 32'd0);
    run_op("rem x/0",    2'b10, 32'h1234, 32'd0);
    run_op("div ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF);

    // kill at cycle 10 of a DIVU
    op = 2'b01; data0 = 32'd1000; data1 = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill busy", {31'b0, busy}, 32'd0);
    chk("kill done", {31'b0, done}, 32'd0);
    chk("kill result", ALU_result, last_exp);
    dones = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (done) dones++; end
    chk("kill no_done", 32'(dones), 32'd0);
    run_op("after kill", 2'b01, 32'd1000, 32'd3);

    // kill together with start in idle
    op = 2'b01; data0 = 32'd50; data1 = 32'd5; start = 1'b1; kill = 1'b1;
    tick();
    start = 1'b0; kill = 1'b0;
    chk("kill+start busy", {31'b0, busy}, 32'd0);
    tick();
    chk("kill+start done", {31'b0, done}, 32'd0);

    // synchronous reset at cycle 20
    op = 2'b00; data0 = 32'hFFFF_0000; data1 = 32'd77; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst busy", {31'b0, busy}, 32'd0);
    chk("midrst done", {31'b0, done}, 32'd0);
    chk("midrst result", ALU_result, 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (done) dones++; end
    chk("midrst no_done", 32'(dones), 32'd0);
    last_exp = '0;

    // start held every cycle while busy
    op = 2'b01; data0 = 32'd5000; data1 = 32'd9; start = 1'b1;
    tick();
    dones = 0;
    for (int i = 0; i < 60 && dones == 0; i++) begin
      data0 = $urandom; data1 = $urandom;
      tick();
      if (done) begin
        dones++;
        start = 1'b0;
        chk("storm result", ALU_result, 32'd555);
      end
    end
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin tick(); if (done) dones++; end
    chk("storm done_count", 32'(dones), 32'd1);

    // back-to-back: start issued in the done cycle
    op = 2'b01; data0 = 32'd100; data1 = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 60) begin tick(); lat++; end
    chk("b2b first", ALU_result, 32'd14);
    op = 2'b11; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b accepted", {31'b0, busy}, 32'd1);
    lat = 1;
    while (!done && lat < 60) begin tick(); lat++; end
    chk("b2b second", ALU_result, 32'd2);
    chk("b2b latency", 32'(lat), 32'd34);
    tick();

    for (int n = 0; n < 1000; n++) begin
      o = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin
          a = $urandom_range(0, 255);
          b = $urandom_range(1, 15);
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        3: begin a = $urandom; b = $urandom_range(1, 1000); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      run_op($sformatf("rand%0d op%0d %h/%h", n, o, a, b), o, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
